uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_edge_cnt.sv | 32 +++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity types and
// prescale limits, used by both the transmitter and receiver.
package uart_pkg;

    // Frame-level FSM states; the encodings are shared with the receiver.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity type selector values
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Smallest bit period honoured; shorter requests are stretched to this.
    localparam int MIN_PRESCALE = 4;

    // Line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_edge_cnt.sv
// Bit timing for the transmitter: counts CLK edges within a bit and
// bits within a frame. Held at zero while disabled.
module uart_tx_edge_cnt #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      bit_done
);

    // Last cycle of the current bit period
    assign bit_done = enable && (edge_cnt == (prescale - PRESCALE_WIDTH'(1)));

    // Edge counter wraps each bit period; bit counter advances on the wrap
    always_ff @(posedge CLK) begin
        if (RST || !enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_WIDTH'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit. Request fields are latched on acceptance so the
// whole frame is immune to input changes while Busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    // Counts frame bits 0..DATA_WIDTH+2 plus the wrap at the end of stop
    localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 4);

    uart_state_e               state;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [PRESCALE_WIDTH-1:0] ps_q;
    logic                      tx_q;
    logic                      busy_q;

    logic                      cnt_en;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic                      bit_done;
    logic                      last_data;
    logic                      par_bit;
    logic [PRESCALE_WIDTH-1:0] ps_clamped;

    // Counters run for every non-idle state; IDLE clears them so the
    // first START cycle always begins a fresh bit period.
    assign cnt_en = (state != IDLE);

    uart_tx_edge_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
    ) u_edge_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (cnt_en),
        .prescale (ps_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    // Frame bit 0 is start, bits 1..DATA_WIDTH are data
    assign last_data = (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH));

    // Odd parity is the inverse of even parity over the latched byte
    assign par_bit = (^data_q) ^ (par_typ_q == ODD);

    // Very short bit periods are stretched to the minimum supported
    assign ps_clamped = (prescale < PRESCALE_WIDTH'(MIN_PRESCALE))
                      ? PRESCALE_WIDTH'(MIN_PRESCALE) : prescale;

    // Frame FSM with registered line and busy outputs. The next line
    // level is loaded on the same edge the state advances, so TX_OUT
    // changes exactly at each bit boundary.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            data_q    <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
            ps_q      <= '0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        shreg     <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        ps_q      <= ps_clamped;
                        tx_q      <= LINE_START;
                        busy_q    <= 1'b1;
                        state     <= START;
                    end else begin
                        tx_q      <= LINE_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (!last_data) begin
                            tx_q  <= shreg[0];
                            shreg <= shreg >> 1;
                        end else if (par_en_q) begin
                            tx_q  <= par_bit;
                            state <= PARITY;
                        end else begin
                            tx_q  <= LINE_STOP;
                            state <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        tx_q  <= LINE_STOP;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        tx_q   <= LINE_IDLE;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // The edge counter must never run past the latched bit period
    a_edge_in_range: assert property (@(posedge CLK) disable iff (RST)
        (state == IDLE) || (edge_cnt < ps_q));

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, parity, prescale latching,
// request dropping while busy, back-to-back spacing and mid-frame reset.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a request; acceptance happens at the next posedge
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps, input bit hold);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) DATA_VALID = 1'b0;
    endtask

    // Check a frame that was accepted at the last posedge. exp[b] is the
    // line level of frame bit b; each bit must last ps cycles. Ends after
    // checking the single idle cycle that follows the stop bit.
    task automatic watch(input string tag, input logic [15:0] exp, input int n, input int ps);
        int busy_cnt;
        busy_cnt = 0;
        for (int b = 0; b < n; b++) begin
            int ok;
            ok = 0;
            for (int c = 0; c < ps; c++) begin
                @(negedge CLK);
                if (TX_OUT === exp[b]) ok++;
                if (Busy === 1'b1) busy_cnt++;
            end
            chk($sformatf("%s bit%0d", tag, b), ok, ps);
        end
        chk($sformatf("%s busy_len", tag), busy_cnt, n * ps);
        @(negedge CLK);
        chk($sformatf("%s idle_tx", tag), {31'd0, TX_OUT}, 1);
        chk($sformatf("%s idle_busy", tag), {31'd0, Busy}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int idle_cnt;
        RST = 1'b1; P_DATA = 8'h00; DATA_VALID = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tx", {31'd0, TX_OUT}, 1);
        chk("rst_busy", {31'd0, Busy}, 0);
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1;

        // 0xA5, no parity, prescale 8
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        watch("a5_np_p8", 16'h034A, 10, 8);

        // 0xA5, even / odd parity, prescale 16
        @(posedge CLK); #1;
        send(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0);
        watch("a5_even_p16", 16'h054A, 11, 16);
        @(posedge CLK); #1;
        send(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0);
        watch("a5_odd_p16", 16'h074A, 11, 16);

        // 0x01, even parity, prescale 32
        @(posedge CLK); #1;
        send(8'h01, 1'b1, 1'b0, 6'd32, 1'b0);
        watch("01_even_p32", 16'h0602, 11, 32);

        // request pulsed mid-frame is dropped
        @(posedge CLK); #1;
        send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
        fork
            watch("3c_drop", 16'h0278, 10, 8);
            begin
                repeat (20) @(posedge CLK);
                #1 P_DATA = 8'hFF; DATA_VALID = 1'b1;
                @(posedge CLK);
                #1 DATA_VALID = 1'b0;
            end
        join
        idle_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (Busy === 1'b0 && TX_OUT === 1'b1) idle_cnt++;
        end
        chk("ff_never_sent", idle_cnt, 12);

        // DATA_VALID held: next START exactly one idle cycle after STOP
        @(posedge CLK); #1;
        send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b1);
        watch("3c_hold_a", 16'h0278, 10, 8);
        @(posedge CLK); #1 DATA_VALID = 1'b0;
        watch("3c_hold_b", 16'h0278, 10, 8);

        // prescale below the minimum is stretched to 4
        @(posedge CLK); #1;
        send(8'h3C, 1'b0, 1'b0, 6'd2, 1'b0);
        watch("3c_p2", 16'h0278, 10, 4);

        // prescale change mid-frame only affects the next frame
        @(posedge CLK); #1;
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        fork
            watch("a5_pschg_cur", 16'h034A, 10, 8);
            begin
                repeat (10) @(posedge CLK);
                #1 prescale = 6'd16;
            end
        join
        @(posedge CLK); #1;
        send(8'hA5, 1'b0, 1'b0, 6'd16, 1'b0);
        watch("a5_pschg_next", 16'h034A, 10, 16);

        // reset during data bit 3, with a request held during reset
        @(posedge CLK); #1;
        send(8'h52, 1'b0, 1'b0, 6'd8, 1'b0);
        repeat (35) @(negedge CLK);
        chk("pre_rst_d3", {31'd0, TX_OUT}, 0);
        RST = 1'b1; DATA_VALID = 1'b1;
        @(negedge CLK);
        chk("mid_rst_tx", {31'd0, TX_OUT}, 1);
        chk("mid_rst_busy", {31'd0, Busy}, 0);
        RST = 1'b0; DATA_VALID = 1'b0;
        @(negedge CLK);
        chk("no_accept_in_rst", {31'd0, Busy}, 0);
        chk("post_rst_tx", {31'd0, TX_OUT}, 1);
        @(posedge CLK); #1;
        send(8'h52, 1'b0, 1'b0, 6'd8, 1'b0);
        watch("52_after_rst", 16'h02A4, 10, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
